pe_pass_scheduler: RTL and testbench

Sequences a group of PEs through a layer job, one pass per (width tile, channel group), and shares the single read port of the input/weight feed buffer among them. Accepts a job over a rdy/ack handshake and drives each PE's `Inst` word (start/stall/reset). It grants buffer reads round-robin and stalls PEs that lose arbitration. Sits between the layer controller and the PE array, one instance per PE column.

---
 rtl/pe_pass_scheduler_pkg.sv | 22 ++
 rtl/pe_pass_scheduler_rr_arbiter.sv | 44 ++++
 rtl/pe_pass_scheduler.sv | 117 +++++++++++
 tb/tb_pe_pass_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pass_scheduler_pkg.sv
// Shared types for the PE pass scheduler: FSM state, per-PE instruction word.
package pe_pass_scheduler_pkg;

  localparam int NPE_MAX = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } sched_state_e;

  // reset=0 holds the PE in IDLE; start is a one-cycle pass kick.
  typedef struct packed {
    logic start;
    logic stall;
    logic reset;
  } inst_t;

  typedef inst_t [NPE_MAX-1:0] pe_inst_vec_t;

endpackage

// File: rtl/pe_pass_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic          found;
  int            idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/pe_pass_scheduler.sv
// Steps a PE group through (tile, channel-group) passes of one layer job and
// arbitrates the shared feed-buffer read port among the PEs.
module pe_pass_scheduler
  import pe_pass_scheduler_pkg::*;
#(
  parameter int NPE = 4,
  parameter int CHW = 4,
  parameter int TW  = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_abort,
  input  logic               Job_rdy,
  output logic               Job_ack,
  input  logic [CHW-1:0]     i_job_ch,
  input  logic [TW-1:0]      i_job_tiles,
  output inst_t [NPE-1:0]    o_PEinst,
  input  logic [NPE-1:0]     i_pe_req,
  output logic [NPE-1:0]     o_pe_grant,
  input  logic               i_buf_rdy,
  input  logic [NPE-1:0]     i_pe_done,
  output logic [CHW-1:0]     o_ch_idx,
  output logic [TW-1:0]      o_tile_idx,
  output logic               o_busy,
  output logic               o_job_done,
  output sched_state_e       o_state
);

  // Job handshake: Job_ack is the same-cycle acceptance of Job_rdy, only in
  // IDLE and never while i_abort is high; the job fields are latched on ack.

  sched_state_e   state, state_nxt;
  logic [CHW-1:0] ch_q;
  logic [TW-1:0]  tiles_q;
  logic [NPE-1:0] done_mask, mask_nxt;
  logic           abort, arb_en, pass_done, last_pass;

  assign o_state   = state;
  assign abort     = i_abort && (state != S_IDLE);
  assign Job_ack   = !i_rst && (state == S_IDLE) && Job_rdy && !i_abort;
  assign arb_en    = !i_rst && !i_abort && (state == S_RUN) && i_buf_rdy;
  assign mask_nxt  = done_mask | i_pe_done;
  assign pass_done = (state == S_RUN) && (&mask_nxt);
  assign last_pass = (o_ch_idx == ch_q - 1'b1) && (o_tile_idx == tiles_q - 1'b1);

  rr_arbiter #(.N(NPE)) u_arb (
    .clk   (i_clk),
    .rst   (i_rst),
    .clr   (abort),
    .req   (i_pe_req),
    .en    (arb_en),
    .grant (o_pe_grant)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Job_ack) state_nxt = (i_job_ch == '0 || i_job_tiles == '0) ? S_DONE : S_START;
      S_START: state_nxt = S_RUN;
      S_RUN:   if (pass_done) state_nxt = last_pass ? S_DONE : S_START;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      ch_q       <= '0;
      tiles_q    <= '0;
      o_ch_idx   <= '0;
      o_tile_idx <= '0;
      done_mask  <= '0;
      o_PEinst   <= '0;
      o_busy     <= 1'b0;
      o_job_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_busy     <= (state_nxt == S_START) || (state_nxt == S_RUN);
      o_job_done <= (state_nxt == S_DONE);
      for (int k = 0; k < NPE; k++) begin
        o_PEinst[k].start <= (state_nxt == S_START);
        o_PEinst[k].reset <= (state_nxt != S_IDLE);
        o_PEinst[k].stall <= (state == S_RUN) && (state_nxt == S_RUN) &&
                             i_pe_req[k] && !o_pe_grant[k];
      end
      if (abort) begin
        o_ch_idx   <= '0;
        o_tile_idx <= '0;
        done_mask  <= '0;
      end else if (Job_ack) begin
        ch_q       <= i_job_ch;
        tiles_q    <= i_job_tiles;
        o_ch_idx   <= '0;
        o_tile_idx <= '0;
        done_mask  <= '0;
      end else if (state == S_RUN) begin
        if (pass_done) begin
          done_mask <= '0;
          if (!last_pass) begin
            if (o_ch_idx == ch_q - 1'b1) begin
              o_ch_idx   <= '0;
              o_tile_idx <= o_tile_idx + 1'b1;
            end else begin
              o_ch_idx <= o_ch_idx + 1'b1;
            end
          end
        end else begin
          done_mask <= mask_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_pass_scheduler.sv
// Directed bench for pe_pass_scheduler: arbitration table, full job walk,
// zero-count job, abort and mid-job reset sequences.
module tb_pe_pass_scheduler;
  import pe_pass_scheduler_pkg::*;

  localparam int NPE = 4;
  localparam int CHW = 4;
  localparam int TW  = 6;

  logic           i_clk = 1'b0;
  logic           i_rst, i_abort, Job_rdy, Job_ack, i_buf_rdy;
  logic [CHW-1:0] i_job_ch, o_ch_idx;
  logic [TW-1:0]  i_job_tiles, o_tile_idx;
  inst_t [NPE-1:0] o_PEinst;
  logic [NPE-1:0] i_pe_req, o_pe_grant, i_pe_done;
  logic           o_busy, o_job_done;
  sched_state_e   o_state;

  logic [NPE-1:0] start_v, stall_v, rst_v;
  logic [TW+CHW-1:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  pe_pass_scheduler #(.NPE(NPE), .CHW(CHW), .TW(TW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_abort     (i_abort),
    .Job_rdy     (Job_rdy),
    .Job_ack     (Job_ack),
    .i_job_ch    (i_job_ch),
    .i_job_tiles (i_job_tiles),
    .o_PEinst    (o_PEinst),
    .i_pe_req    (i_pe_req),
    .o_pe_grant  (o_pe_grant),
    .i_buf_rdy   (i_buf_rdy),
    .i_pe_done   (i_pe_done),
    .o_ch_idx    (o_ch_idx),
    .o_tile_idx  (o_tile_idx),
    .o_busy      (o_busy),
    .o_job_done  (o_job_done),
    .o_state     (o_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always_comb begin
    start_v = '0;
    stall_v = '0;
    rst_v   = '0;
    for (int k = 0; k < NPE; k++) begin
      start_v[k] = o_PEinst[k].start;
      stall_v[k] = o_PEinst[k].stall;
      rst_v[k]   = o_PEinst[k].reset;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after posedge, checks at negedge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  task automatic drive(input logic [3:0] req, input logic rdy, input logic [3:0] done,
                       input logic abrt, input logic jrdy);
    i_pe_req  = req;
    i_buf_rdy = rdy;
    i_pe_done = done;
    i_abort   = abrt;
    Job_rdy   = jrdy;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] done;
    logic [3:0] exp_grant;
    logic [3:0] exp_stall;
  } vec_t;

  vec_t vecs[16];

  int starts, since, drove_cur, drove_prev, done_seen;

  initial begin
    vecs[0]  = '{4'b0101, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0101, 1'b0, 4'b0000, 4'b0000, 4'b0101};
    vecs[2]  = '{4'b0101, 1'b0, 4'b0000, 4'b0000, 4'b0101};
    vecs[3]  = '{4'b0101, 1'b1, 4'b0000, 4'b0001, 4'b0101};
    vecs[4]  = '{4'b0100, 1'b1, 4'b0000, 4'b0100, 4'b0100};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0000, 4'b1000, 4'b0000};
    vecs[6]  = '{4'b1111, 1'b1, 4'b0000, 4'b0001, 4'b0111};
    vecs[7]  = '{4'b1111, 1'b1, 4'b0000, 4'b0010, 4'b1110};
    vecs[8]  = '{4'b1111, 1'b1, 4'b0000, 4'b0100, 4'b1101};
    vecs[9]  = '{4'b1111, 1'b1, 4'b0000, 4'b1000, 4'b1011};
    vecs[10] = '{4'b1111, 1'b1, 4'b0000, 4'b0001, 4'b0111};
    vecs[11] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1110};
    vecs[12] = '{4'b0001, 1'b1, 4'b0000, 4'b0001, 4'b0000};
    vecs[13] = '{4'b0000, 1'b1, 4'b0011, 4'b0000, 4'b0000};
    vecs[14] = '{4'b0000, 1'b1, 4'b0100, 4'b0000, 4'b0000};
    vecs[15] = '{4'b0000, 1'b1, 4'b1000, 4'b0000, 4'b0000};

    i_rst = 1'b1;
    i_job_ch = '0;
    i_job_tiles = '0;
    drive(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    repeat (3) tick();
    sample();
    check("rst_state", o_state, S_IDLE);
    check("rst_inst", o_PEinst, '0);
    check("rst_grant", o_pe_grant, '0);
    check("rst_flags", {Job_ack, o_job_done, o_busy}, 3'b000);
    check("rst_idx", {o_tile_idx, o_ch_idx}, '0);

    // single-pass job carrying the arbitration table
    tick();
    i_rst = 1'b0;
    i_job_ch = 4'd1;
    i_job_tiles = 6'd1;
    drive(4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
    sample();
    check("t1_ack", Job_ack, 1'b1);
    tick();
    drive(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    sample();
    check("t1_start", {start_v, rst_v, o_busy}, {4'hF, 4'hF, 1'b1});
    check("t1_start_state", o_state, S_START);
    for (int i = 0; i < 16; i++) begin
      tick();
      drive(vecs[i].req, vecs[i].rdy, vecs[i].done, 1'b0, 1'b0);
      sample();
      check($sformatf("arb%0d_grant", i), o_pe_grant, vecs[i].exp_grant);
      check($sformatf("arb%0d_stall", i), stall_v, vecs[i].exp_stall);
      check($sformatf("arb%0d_run", i), {o_state, rst_v, start_v}, {S_RUN, 4'hF, 4'h0});
    end
    tick();
    drive(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    sample();
    check("t1_done", {o_job_done, o_busy, start_v}, {1'b1, 1'b0, 4'h0});
    check("t1_done_state", o_state, S_DONE);
    tick();
    sample();
    check("t1_idle", {o_job_done, o_state}, {1'b0, S_IDLE});

    // full job ch=2 tiles=3, all PEs pulse done 5 cycles after each start
    for (int t = 0; t < 3; t++)
      for (int c = 0; c < 2; c++)
        exp_q.push_back({TW'(t), CHW'(c)});
    tick();
    i_job_ch = 4'd2;
    i_job_tiles = 6'd3;
    drive(4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
    sample();
    check("t2_ack", Job_ack, 1'b1);
    starts = 0;
    since = -100;
    drove_cur = 0;
    drove_prev = 0;
    done_seen = 0;
    for (int cyc = 0; cyc < 200 && done_seen == 0; cyc++) begin
      tick();
      since++;
      drove_prev = drove_cur;
      drove_cur = (since == 5) ? 1 : 0;
      drive(4'b0, 1'b0, (drove_cur != 0) ? 4'hF : 4'h0, 1'b0, 1'b0);
      sample();
      if (start_v == 4'hF) begin
        if (starts > 0) check($sformatf("t2_gap%0d", starts), drove_prev, 1);
        if (exp_q.size() == 0) begin
          check("t2_extra_start", 1'b1, 1'b0);
        end else begin
          check($sformatf("t2_idx%0d", starts), {o_tile_idx, o_ch_idx}, exp_q.pop_front());
        end
        starts++;
        since = 0;
      end
      if (o_job_done) begin
        check("t2_done_gap", drove_prev, 1);
        check("t2_starts", starts, 6);
        check("t2_q_empty", exp_q.size(), 0);
        done_seen = 1;
      end
    end
    if (done_seen == 0) check("t2_timeout", 1'b0, 1'b1);
    tick();
    drive(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    sample();
    check("t2_idle", {o_state, o_job_done}, {S_IDLE, 1'b0});

    // zero channel-group count: ack then done with no start pulse
    tick();
    i_job_ch = 4'd0;
    i_job_tiles = 6'd3;
    drive(4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
    sample();
    check("t3_ack", Job_ack, 1'b1);
    tick();
    drive(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    sample();
    check("t3_done", {o_job_done, o_busy, start_v}, {1'b1, 1'b0, 4'h0});
    tick();
    sample();
    check("t3_idle", {o_job_done, o_state}, {1'b0, S_IDLE});

    // abort in RUN with simultaneous pass completion, then rdy+abort in IDLE
    tick();
    i_job_ch = 4'd1;
    i_job_tiles = 6'd2;
    drive(4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
    sample();
    check("t4_ack", Job_ack, 1'b1);
    tick();
    drive(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    sample();
    check("t4_start", start_v, 4'hF);
    tick();
    drive(4'b0010, 1'b1, 4'b0, 1'b0, 1'b0);
    sample();
    check("t4_pre_grant", o_pe_grant, 4'b0010);
    tick();
    drive(4'b1111, 1'b1, 4'hF, 1'b1, 1'b0);
    sample();
    check("t4_abort_grant", o_pe_grant, 4'b0000);
    tick();
    drive(4'b0, 1'b0, 4'b0, 1'b1, 1'b1);
    sample();
    check("t4_abort_inst", {rst_v, start_v}, 8'h00);
    check("t4_abort_flags", {o_job_done, o_busy, Job_ack}, 3'b000);
    check("t4_abort_state", o_state, S_IDLE);
    check("t4_abort_idx", {o_tile_idx, o_ch_idx}, '0);
    tick();
    drive(4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
    sample();
    check("t4_reack", Job_ack, 1'b1);
    tick();
    drive(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    sample();
    check("t4_restart", start_v, 4'hF);
    tick();
    drive(4'b1111, 1'b1, 4'b0, 1'b0, 1'b0);
    sample();
    check("t4_ptr_cleared", o_pe_grant, 4'b0001);

    // reset in the middle of a job
    tick();
    i_rst = 1'b1;
    drive(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    tick();
    i_rst = 1'b0;
    sample();
    check("t5_rst_state", {o_state, o_busy, o_job_done}, {S_IDLE, 1'b0, 1'b0});
    check("t5_rst_inst", o_PEinst, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
